// File: rtl/bit_serial_sub_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The bench drives through master and the subtractor attaches as slave.
interface bit_serial_sub_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/bit_serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, through
// a single full-subtractor cell. It also reports the final borrow and the signed overflow.
module bit_serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bit_serial_sub_ctrl_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic             r_br;
   logic             r_bout;
   logic             r_ovf;
   logic [CW-1:0]    r_cnt;

   logic             w_ai;
   logic             w_bi;
   logic             w_d;
   logic             w_bo;
   logic             w_last;
   logic             w_load;
   logic             w_busy;
   logic             w_done;

   // Full-subtractor cell on the current LSBs of the operand shift registers
   assign w_ai   = r_a[0];
   assign w_bi   = r_b[0];
   assign w_d    = w_ai ^ w_bi ^ r_br;
   assign w_bo   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_load = 1'b1;
               w_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            if (bus.start) begin
               w_load = 1'b1;
               w_next = S_SHIFT;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Results are left untouched on load so they hold until shifting resumes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_diff <= '0;
         r_br   <= 1'b0;
         r_bout <= 1'b0;
         r_ovf  <= 1'b0;
         r_cnt  <= '0;
      end else if (w_load) begin
         r_a   <= bus.a;
         r_b   <= bus.b;
         r_br  <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
         r_diff <= {w_d, r_diff[WIDTH-1:1]};
         r_a    <= r_a >> 1;
         r_b    <= r_b >> 1;
         r_br   <= w_bo;
         if (w_last) begin
            // The cell now sees the original sign bits of a and b
            r_bout <= w_bo;
            r_ovf  <= (w_ai != w_bi) && (w_d != w_ai);
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.diff = r_diff;
   assign bus.bout = r_bout;
   assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bit_serial_sub_ctrl.sv
// Directed bench for bit_serial_sub_ctrl: vector table, busy-time start, back-to-back,
// asynchronous abort and random operands at WIDTH 8 and 32.
module tb_bit_serial_sub_ctrl;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   bit_serial_sub_ctrl_if #(.WIDTH(8))  bus8 ();
   bit_serial_sub_ctrl_if #(.WIDTH(32)) bus32 ();

   bit_serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   bit_serial_sub_ctrl #(.WIDTH(32)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: {ovf, bout, diff} of a - b at width w
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [31:0] mask;
      logic [31:0] am;
      logic [31:0] bm;
      logic [31:0] d;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      am   = a & mask;
      bm   = b & mask;
      d    = (am - bm) & mask;
      return {((am[w-1] != bm[w-1]) && (d[w-1] != am[w-1])), (am < bm), d};
   endfunction

   task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb, input logic eo, input int inj);
      int         lat;
      int         np;
      logic [7:0] cd;
      logic       cb;
      logic       co;
      lat = -1;
      np  = 0;
      cd  = '0;
      cb  = 1'b0;
      co  = 1'b0;
      @(negedge clk);
      bus8.a     = a;
      bus8.b     = b;
      bus8.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         if (k == inj) begin
            bus8.start = 1'b1;
            bus8.a     = 8'hFF;
            bus8.b     = 8'h00;
         end else begin
            bus8.start = 1'b0;
            bus8.a     = 8'($urandom);
            bus8.b     = 8'($urandom);
         end
         @(posedge clk);
         #1;
         if (k == 1) check({nm, "_busy_first"}, 32'(bus8.busy), 32'd1);
         if (k == 8) check({nm, "_busy_last"}, 32'(bus8.busy), 32'd0);
         if (bus8.done) begin
            np++;
            if (lat < 0) begin
               lat = k;
               cd  = bus8.diff;
               cb  = bus8.bout;
               co  = bus8.ovf;
            end
         end
      end
      bus8.start = 1'b0;
      check({nm, "_latency"}, 32'(lat), 32'd8);
      check({nm, "_pulses"}, 32'(np), 32'd1);
      check({nm, "_diff"}, 32'(cd), 32'(ed));
      check({nm, "_bout"}, 32'(cb), 32'(eb));
      check({nm, "_ovf"}, 32'(co), 32'(eo));
      check({nm, "_hold"}, 32'(bus8.diff), 32'(ed));
   endtask

   task automatic run32(input string nm, input logic [31:0] a, input logic [31:0] b);
      logic [33:0] m;
      int          lat;
      int          np;
      logic [31:0] cd;
      logic        cb;
      logic        co;
      m   = model(a, b, 32);
      lat = -1;
      np  = 0;
      cd  = '0;
      cb  = 1'b0;
      co  = 1'b0;
      @(negedge clk);
      bus32.a     = a;
      bus32.b     = b;
      bus32.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus32.start = 1'b0;
      for (int k = 1; k <= 35; k++) begin
         bus32.a = $urandom;
         bus32.b = $urandom;
         @(posedge clk);
         #1;
         if (bus32.done) begin
            np++;
            if (lat < 0) begin
               lat = k;
               cd  = bus32.diff;
               cb  = bus32.bout;
               co  = bus32.ovf;
            end
         end
      end
      check({nm, "_latency"}, 32'(lat), 32'd32);
      check({nm, "_pulses"}, 32'(np), 32'd1);
      check({nm, "_diff"}, cd, m[31:0]);
      check({nm, "_bout"}, 32'(cb), 32'(m[32]));
      check({nm, "_ovf"}, 32'(co), 32'(m[33]));
   endtask

   initial begin
      logic [7:0]  pa[3];
      logic [7:0]  pb[3];
      logic [33:0] m;
      logic [7:0]  ra;
      logic [7:0]  rb;
      int          np;

      n_vec = 0;
      n_err = 0;

      tbl[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
      tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
      tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      tbl[3] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b0};
      tbl[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
      tbl[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
      tbl[6] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
      tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
      tbl[8] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[9] = '{8'hC3, 8'h42, 8'h81, 1'b0, 1'b0};

      rst_n       = 1'b0;
      bus8.start  = 1'b0;
      bus8.a      = '0;
      bus8.b      = '0;
      bus32.start = 1'b0;
      bus32.a     = '0;
      bus32.b     = '0;

      #2;
      check("rst_busy", 32'(bus8.busy), 32'd0);
      check("rst_done", 32'(bus8.done), 32'd0);
      check("rst_diff", 32'(bus8.diff), 32'd0);
      check("rst_bout", 32'(bus8.bout), 32'd0);
      check("rst_ovf", 32'(bus8.ovf), 32'd0);
      check("rst_diff32", bus32.diff, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].bout, tbl[i].ovf, 0);
      end

      // start pulse while busy must be ignored
      run_op("busy_start", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 3);

      // start held high: a new pair accepted every 9 cycles
      pa[0] = 8'h5A; pb[0] = 8'h3C;
      pa[1] = 8'h00; pb[1] = 8'h01;
      pa[2] = 8'h80; pb[2] = 8'h01;
      np = 0;
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a     = pa[0];
      bus8.b     = pb[0];
      @(posedge clk);
      for (int c = 1; c <= 28; c++) begin
         @(negedge clk);
         bus8.start = (c <= 18);
         bus8.a     = pa[(c <= 18) ? c / 9 : 2];
         bus8.b     = pb[(c <= 18) ? c / 9 : 2];
         @(posedge clk);
         #1;
         if (bus8.done) begin
            np++;
            check("b2b_phase", 32'(c % 9), 32'd8);
            m = model(32'(pa[(c / 9) % 3]), 32'(pb[(c / 9) % 3]), 8);
            check("b2b_diff", 32'(bus8.diff), 32'(m[7:0]));
            check("b2b_bout", 32'(bus8.bout), 32'(m[32]));
            check("b2b_ovf", 32'(bus8.ovf), 32'(m[33]));
         end
      end
      bus8.start = 1'b0;
      check("b2b_pulses", 32'(np), 32'd3);

      // asynchronous reset in the middle of a shift
      @(negedge clk);
      bus8.a     = 8'hFF;
      bus8.b     = 8'h00;
      bus8.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus8.busy), 32'd0);
      check("abort_done", 32'(bus8.done), 32'd0);
      check("abort_diff", 32'(bus8.diff), 32'd0);
      check("abort_bout", 32'(bus8.bout), 32'd0);
      check("abort_ovf", 32'(bus8.ovf), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      np = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus8.done) np++;
      end
      check("abort_no_done", 32'(np), 32'd0);
      run_op("after_abort", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 0);

      for (int i = 0; i < 4; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         m  = model(32'(ra), 32'(rb), 8);
         run_op($sformatf("rnd8_%0d", i), ra, rb, m[7:0], m[32], m[33], 0);
      end

      run32("w32_zero_minus_one", 32'h0000_0000, 32'h0000_0001);
      run32("w32_min_minus_one", 32'h8000_0000, 32'h0000_0001);
      for (int i = 0; i < 4; i++) begin
         run32($sformatf("rnd32_%0d", i), $urandom, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
